// File: rtl/rgb_stream_scoreboard_if.sv
// Handshake bundle between a reference-model pusher / DUT monitor and the scoreboard.
// The master drives the expected and observed beats; the slave (scoreboard) returns exp_ready_o.
interface rgb_stream_scoreboard_if #(
    parameter int DW = 27
) ();
    logic          exp_valid_i;
    logic          exp_ready_o;
    logic [DW-1:0] exp_data_i;
    logic          act_valid_i;
    logic          act_ready_i;
    logic [DW-1:0] act_data_i;

    modport master (
        output exp_valid_i, exp_data_i, act_valid_i, act_ready_i, act_data_i,
        input  exp_ready_o
    );

    modport slave (
        input  exp_valid_i, exp_data_i, act_valid_i, act_ready_i, act_data_i,
        output exp_ready_o
    );
endinterface

// File: rtl/rgb_stream_scoreboard.sv
// In-order pixel-stream scoreboard: expected-beat FIFO, one-stage compare, saturating result counters.
// Optional RGB_SB_CAPTURE_EN adds capture of the first mismatching pair and its cycle stamp.
module rgb_stream_scoreboard #(
    parameter int NCHAN = 3,
    parameter int CW    = 8,
    parameter int SBW   = 3,
    parameter int DEPTH = 8,
    parameter int TOL   = 3,
    parameter int CNTW  = 16,
    parameter int HALT  = 1,
    localparam int DW   = NCHAN*CW+SBW,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    rgb_stream_scoreboard_if.slave bus,
    output logic [AW:0]           fill_o,
    output logic [CNTW-1:0]       match_cnt_o,
    output logic [CNTW-1:0]       margin_cnt_o,
    output logic [CNTW-1:0]       mismatch_cnt_o,
    output logic                  underflow_o,
    output logic                  overflow_o,
    output logic                  error_o,
    output logic                  halted_o
`ifdef RGB_SB_CAPTURE_EN
    ,
    output logic [DW-1:0]         err_exp_o,
    output logic [DW-1:0]         err_act_o,
    output logic [31:0]           err_cyc_o
`endif
);
    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     mem_q [DEPTH];
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d, fill;
    logic              cmp_vld_q, cmp_vld_d;
    logic [DW-1:0]     cmp_exp_q, cmp_exp_d, cmp_act_q, cmp_act_d;
    logic [CNTW-1:0]   match_q, match_d, margin_q, margin_d, mis_q, mis_d;
    logic              uf_q, uf_d, of_q, of_d, err_q, err_d;

    logic              empty, full, act_fire, push, pop, classify, halt_now, run_ok;
    logic              sb_diff, is_mis, is_match, uf_evt, of_evt;
    logic [NCHAN-1:0]  ch_eq, ch_out;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Per-channel absolute difference, one bit wider than the channel so it never wraps.
    generate
        for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
            logic [CW:0] e_w, a_w, diff_w;
            assign e_w       = {1'b0, cmp_exp_q[SBW+CW*gi +: CW]};
            assign a_w       = {1'b0, cmp_act_q[SBW+CW*gi +: CW]};
            assign diff_w    = (e_w >= a_w) ? (e_w - a_w) : (a_w - e_w);
            assign ch_eq[gi] = (diff_w == '0);
            assign ch_out[gi] = (diff_w > (CW+1)'(TOL));
        end
    endgenerate

    assign sb_diff  = cmp_exp_q[SBW-1:0] != cmp_act_q[SBW-1:0];
    assign is_mis   = sb_diff | (|ch_out);
    assign is_match = ~is_mis & (&ch_eq);

    assign fill     = wr_q - rd_q;
    assign empty    = (fill == '0);
    assign full     = (fill == (AW+1)'(DEPTH));
    assign act_fire = bus.act_valid_i & bus.act_ready_i;
    assign classify = cmp_vld_q & (state_q == ST_RUN);
    assign halt_now = classify & is_mis & (HALT != 0);
    // The cycle that classifies a halting mismatch already behaves as HALTED, so no beat slips through.
    assign run_ok   = (state_q == ST_RUN) & ~halt_now;
    assign pop      = act_fire & run_ok & ~empty & ~clear_i;
    assign bus.exp_ready_o = ~full | pop;
    assign push     = bus.exp_valid_i & bus.exp_ready_o & ~clear_i;
    assign uf_evt   = act_fire & empty & run_ok;
    assign of_evt   = bus.exp_valid_i & ~bus.exp_ready_o;

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        cmp_vld_d = 1'b0;
        cmp_exp_d = cmp_exp_q;
        cmp_act_d = cmp_act_q;
        match_d   = match_q;
        margin_d  = margin_q;
        mis_d     = mis_q;
        uf_d      = uf_q;
        of_d      = of_q;
        err_d     = err_q;
        if (clear_i) begin
            state_d  = ST_RUN;
            wr_d     = '0;
            rd_d     = '0;
            match_d  = '0;
            margin_d = '0;
            mis_d    = '0;
            uf_d     = 1'b0;
            of_d     = 1'b0;
            err_d    = 1'b0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop) begin
                rd_d      = rd_q + 1'b1;
                cmp_vld_d = 1'b1;
                cmp_exp_d = mem_q[rd_q[AW-1:0]];
                cmp_act_d = bus.act_data_i;
            end
            if (classify) begin
                if (is_mis)        mis_d    = sat_inc(mis_q);
                else if (is_match) match_d  = sat_inc(match_q);
                else               margin_d = sat_inc(margin_q);
            end
            if (halt_now) state_d = ST_HALTED;
            if (uf_evt)   uf_d    = 1'b1;
            if (of_evt)   of_d    = 1'b1;
            if (uf_evt || of_evt || (classify && is_mis)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q[AW-1:0]] <= bus.exp_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_RUN;
            wr_q      <= '0;
            rd_q      <= '0;
            cmp_vld_q <= 1'b0;
            cmp_exp_q <= '0;
            cmp_act_q <= '0;
            match_q   <= '0;
            margin_q  <= '0;
            mis_q     <= '0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            cmp_vld_q <= cmp_vld_d;
            cmp_exp_q <= cmp_exp_d;
            cmp_act_q <= cmp_act_d;
            match_q   <= match_d;
            margin_q  <= margin_d;
            mis_q     <= mis_d;
            uf_q      <= uf_d;
            of_q      <= of_d;
            err_q     <= err_d;
        end
    end

    assign fill_o         = fill;
    assign match_cnt_o    = match_q;
    assign margin_cnt_o   = margin_q;
    assign mismatch_cnt_o = mis_q;
    assign underflow_o    = uf_q;
    assign overflow_o     = of_q;
    assign error_o        = err_q;
    assign halted_o       = (state_q == ST_HALTED);

`ifdef RGB_SB_CAPTURE_EN
    logic [31:0]   cyc_q, cyc_d, ecyc_q, ecyc_d;
    logic [DW-1:0] eexp_q, eexp_d, eact_q, eact_d;
    logic          cap_q, cap_d;

    always_comb begin
        cyc_d  = cyc_q + 1'b1;
        ecyc_d = ecyc_q;
        eexp_d = eexp_q;
        eact_d = eact_q;
        cap_d  = cap_q;
        if (clear_i) begin
            ecyc_d = '0;
            eexp_d = '0;
            eact_d = '0;
            cap_d  = 1'b0;
        end else if (classify && is_mis && !cap_q) begin
            ecyc_d = cyc_q;
            eexp_d = cmp_exp_q;
            eact_d = cmp_act_q;
            cap_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q  <= '0;
            ecyc_q <= '0;
            eexp_q <= '0;
            eact_q <= '0;
            cap_q  <= 1'b0;
        end else begin
            cyc_q  <= cyc_d;
            ecyc_q <= ecyc_d;
            eexp_q <= eexp_d;
            eact_q <= eact_d;
            cap_q  <= cap_d;
        end
    end

    assign err_exp_o = eexp_q;
    assign err_act_o = eact_q;
    assign err_cyc_o = ecyc_q;
`endif
endmodule
